keypad_entry: RTL
=================

// Module: keypad_entry
// PURPOSE
//   Consumes the 4-bit key code from the keypad scanner (15 = no key) and turns it into
//   clean, single-shot key events. Keys 0-9 are accumulated into a DIGITS-wide BCD entry
//   buffer; key 10 deletes/clears; key 11 commits (enter). Output feeds 7-seg display and
//   any consumer that needs a multi-digit number.
// PARAMETERS
//   DEBOUNCE_CYCLES  2_000_000  consecutive stable sys_clk_in samples to accept a press or release (>=1)
//   DIGITS           4          BCD digits held in the entry buffer (>=1)
// PORTS
//   sys_clk_in    in   1             system clock; all logic on rising edge
//   reset         in   1             asynchronous, active-high reset
//   num           in   4             key code from scanner: 0-9 digit, 10 delete, 11 enter, 12-14 ignored, 15 none
//   value_bcd     out  4*DIGITS      live entry buffer; nibble 0 = most recent digit
//   digit_count   out  $clog2(DIGITS+1)  digits currently in buffer (0..DIGITS)
//   key_valid     out  1             1-cycle pulse per accepted key press
//   key_code      out  4             code of last accepted key
//   entered       out  1             1-cycle pulse when key 11 accepted
//   entered_bcd   out  4*DIGITS      buffer snapshot latched on enter
//   overflow      out  1             sticky: digit pressed while buffer full
// BEHAVIOUR
//   Reset (async, immediate): value_bcd=0, digit_count=0, key_valid=0, key_code=15,
//     entered=0, entered_bcd=0, overflow=0, FSM=IDLE, debounce counter=0, sync flops=15.
//   Input sync: num passes a 2-flop synchronizer (s2); FSM uses s2 only.
//   FSM (counter cnt, candidate cand):
//     IDLE      : s2!=15 -> cand<=s2, cnt<=0, PRESS_DB.
//     PRESS_DB  : s2!=cand -> IDLE (glitch rejected, no event); else cnt++;
//                 on matching sample with cnt==DEBOUNCE_CYCLES-1 -> accept cand, HELD.
//     HELD      : s2==15 -> cnt<=0, REL_DB; any other code (incl. changed key) ignored.
//     REL_DB    : s2!=15 -> HELD; on s2==15 with cnt==DEBOUNCE_CYCLES-1 -> IDLE.
//   Exactly one key event per press; no auto-repeat; a second key pressed while one is
//     held produces no event until full release.
//   Latency: num first sampled with code at edge N -> key_valid high in the cycle after
//     edge N+DEBOUNCE_CYCLES+2; action on buffer/outputs visible in that same cycle.
//   On accept (key_valid=1, key_code<=cand), by code:
//     0-9  : digit_count<DIGITS -> value_bcd<={value_bcd[4*DIGITS-5:0],code}, count+1;
//            digit_count==DIGITS -> buffer unchanged, overflow<=1.
//            Leading zeros are stored and counted.
//     10   : see CONFIGURATION.
//     11   : entered pulse; entered_bcd<=value_bcd; value_bcd<=0, count<=0, overflow<=0.
//            Enter with empty buffer still pulses, entered_bcd=0.
//     12-14: key_valid pulses only; buffer, count, overflow unchanged.
//   key_valid and entered are never high for more than one consecutive cycle.
//   Reset mid-press: all state cleared; a key still held after reset release is treated
//     as a new press and accepted once after normal debounce.
// CONFIGURATION
//   KEYPAD_ENTRY_BACKSPACE_EN defined: key 10 = backspace: count>0 -> value_bcd>>=4,
//     count-1, overflow<=0; count==0 -> no change (key_valid still pulses).
//   Not defined: key 10 = clear-all: value_bcd<=0, count<=0, overflow<=0.
// TESTING  (DEBOUNCE_CYCLES=8, DIGITS=4)
//   num=5 for 30 cycles then 15 for 30 -> one key_valid, key_code=5, value_bcd=16'h0005, count=1.
//   num=7 for 4 cycles then 15 -> no key_valid; buffer unchanged.
//   Press 5, release bounces (15 x3, 5 x2, then 15) -> exactly one key_valid.
//   Keys 1,2,3,4,11 -> entered pulse, entered_bcd=16'h1234, value_bcd=0, count=0.
//   Keys 1..5 -> value_bcd=16'h1234, overflow=1; key 10 -> no macro: 0/count 0/overflow 0;
//     with KEYPAD_ENTRY_BACKSPACE_EN: 16'h0123, count=3, overflow=0.
//   reset pulsed during PRESS_DB with num=8 held -> all outputs at reset values; after
//     release, key 8 accepted once, key_valid 10 cycles after first post-reset edge.

Source files
------------

// File: rtl/keypad_entry.sv
// rtl/keypad_entry.sv - debounced keypad key events feeding a multi-digit BCD entry buffer
//
// Purpose: synchronises the scanner key code, debounces press and release, emits one
// event per press and maintains a DIGITS-wide BCD entry buffer (nibble 0 = newest digit).
// Key 10 clears the buffer, or deletes the newest digit when KEYPAD_ENTRY_BACKSPACE_EN
// is defined. Key 11 commits the buffer to entered_bcd and empties it.
//
// Ports:
//   sys_clk_in   in   system clock, rising edge
//   reset        in   asynchronous active-high reset
//   num          in   scanner key code (0-9 digit, 10 delete, 11 enter, 12-14 ignored, 15 none)
//   value_bcd    out  live entry buffer
//   digit_count  out  digits held in the buffer
//   key_valid    out  one-cycle pulse per accepted key
//   key_code     out  code of the last accepted key
//   entered      out  one-cycle pulse on accepted enter
//   entered_bcd  out  buffer snapshot taken on enter
//   overflow     out  sticky flag: digit pressed while buffer full
//
// Build option: KEYPAD_ENTRY_BACKSPACE_EN
module keypad_entry #(
    parameter int DEBOUNCE_CYCLES = 2_000_000,
    parameter int DIGITS          = 4
) (
    input  logic                         sys_clk_in,
    input  logic                         reset,
    input  logic [3:0]                   num,
    output logic [4*DIGITS-1:0]          value_bcd,
    output logic [$clog2(DIGITS+1)-1:0]  digit_count,
    output logic                         key_valid,
    output logic [3:0]                   key_code,
    output logic                         entered,
    output logic [4*DIGITS-1:0]          entered_bcd,
    output logic                         overflow
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int NW = $clog2(DIGITS + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [NW-1:0] FULL     = NW'(DIGITS);
    localparam logic [3:0]    NO_KEY   = 4'd15;

    typedef enum logic [1:0] {IDLE, PRESS_DB, HELD, REL_DB} state_t;

    state_t              state_q, state_d;
    logic [3:0]          sync1_q, sync2_q;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [3:0]          cand_q, cand_d;
    logic [4*DIGITS-1:0] value_q, value_d;
    logic [NW-1:0]       count_q, count_d;
    logic                kv_q, kv_d;
    logic [3:0]          code_q, code_d;
    logic                ent_q, ent_d;
    logic [4*DIGITS-1:0] entbcd_q, entbcd_d;
    logic                ovf_q, ovf_d;
    logic                accept;

    always_ff @(posedge sys_clk_in or posedge reset) begin
        if (reset) begin
            sync1_q  <= NO_KEY;
            sync2_q  <= NO_KEY;
            state_q  <= IDLE;
            cnt_q    <= '0;
            cand_q   <= NO_KEY;
            value_q  <= '0;
            count_q  <= '0;
            kv_q     <= 1'b0;
            code_q   <= NO_KEY;
            ent_q    <= 1'b0;
            entbcd_q <= '0;
            ovf_q    <= 1'b0;
        end else begin
            sync1_q  <= num;
            sync2_q  <= sync1_q;
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            cand_q   <= cand_d;
            value_q  <= value_d;
            count_q  <= count_d;
            kv_q     <= kv_d;
            code_q   <= code_d;
            ent_q    <= ent_d;
            entbcd_q <= entbcd_d;
            ovf_q    <= ovf_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        cand_d   = cand_q;
        value_d  = value_q;
        count_d  = count_q;
        kv_d     = 1'b0;
        code_d   = code_q;
        ent_d    = 1'b0;
        entbcd_d = entbcd_q;
        ovf_d    = ovf_q;
        accept   = 1'b0;

        case (state_q)
            IDLE: begin
                if (sync2_q != NO_KEY) begin
                    cand_d  = sync2_q;
                    cnt_d   = '0;
                    state_d = PRESS_DB;
                end
            end
            PRESS_DB: begin
                // Any change of code during the press window is a glitch: drop it silently.
                if (sync2_q != cand_q) begin
                    state_d = IDLE;
                end else if (cnt_q == CNT_LAST) begin
                    accept  = 1'b1;
                    state_d = HELD;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            HELD: begin
                // Other keys while held are ignored until a clean full release.
                if (sync2_q == NO_KEY) begin
                    cnt_d   = '0;
                    state_d = REL_DB;
                end
            end
            REL_DB: begin
                if (sync2_q != NO_KEY) begin
                    state_d = HELD;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        if (accept) begin
            kv_d   = 1'b1;
            code_d = cand_q;
            if (cand_q < 4'd10) begin
                if (count_q < FULL) begin
                    value_d      = value_q << 4;
                    value_d[3:0] = cand_q;
                    count_d      = count_q + 1'b1;
                end else begin
                    ovf_d = 1'b1;
                end
            end else if (cand_q == 4'd10) begin
`ifdef KEYPAD_ENTRY_BACKSPACE_EN
                if (count_q != '0) begin
                    value_d = value_q >> 4;
                    count_d = count_q - 1'b1;
                    ovf_d   = 1'b0;
                end
`else
                value_d = '0;
                count_d = '0;
                ovf_d   = 1'b0;
`endif
            end else if (cand_q == 4'd11) begin
                ent_d    = 1'b1;
                entbcd_d = value_q;
                value_d  = '0;
                count_d  = '0;
                ovf_d    = 1'b0;
            end
        end
    end

    assign value_bcd   = value_q;
    assign digit_count = count_q;
    assign key_valid   = kv_q;
    assign key_code    = code_q;
    assign entered     = ent_q;
    assign entered_bcd = entbcd_q;
    assign overflow    = ovf_q;

endmodule
